// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux scan sequencer: the channel count, the
// channel index width and the scan state encoding.
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Settle-time counter for one mux channel. It counts up while enabled and
// returns to zero on clear. 'expired' flags the last settle cycle.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   clear   in   force the count to zero (has priority over enable)
//   enable  in   advance the count by one
//   expired out  count == DWELL-1
// ---------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
// Drives the select lines of a 4:1 mux through channels 0..3, waits DWELL
// settle cycles on each, samples the mux output, and publishes the four
// samples as one word together with a one-cycle valid strobe. Supports a
// single scan per start or back-to-back continuous scanning.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   scan request, only looked at while idle
//   cont      in   continuous mode, looked at on the channel-3 sample
//   y         in   mux output for the current select
//   s0, s1    out  registered select lines ({s1,s0} = channel)
//   busy      out  high whenever a scan is in progress
//   valid     out  one-cycle strobe, data updated in the same cycle
//   data      out  data[k] = sample taken on channel k
//   scan_cnt  out  completed scans, wraps 255 -> 0
// ---------------------------------------------------------------------------
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       y,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       valid,
    output logic [3:0] data,
    output logic [7:0] scan_cnt
);

    // Reject settle times the counter cannot represent at elaboration.
    if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
        $error("mux_scan_sequencer: DWELL must be in 1..15");
    end
    if ((DWELL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("mux_scan_sequencer: CNT_W too narrow for DWELL-1");
    end

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t            state_d, state_q;
    logic [CH_W-1:0]   ch_d, ch_q;
    logic [NUM_CH-2:0] shadow_d, shadow_q;
    logic [3:0]        data_d, data_q;
    logic              valid_d, valid_q;
    logic [7:0]        scan_cnt_d, scan_cnt_q;
    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_expired;

    dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // The timer is held at zero outside SETTLE, so every channel starts its
    // settle window from a clean count. Channels 0..2 land in the shadow
    // register; only a completed channel-3 sample commits to data, so an
    // aborted scan can never leak into the published word.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        scan_cnt_d = scan_cnt_q;
        tmr_clear  = 1'b1;
        tmr_enable = 1'b0;

        case (state_q)
            IDLE: begin
                ch_d = '0;
                if (start) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_expired) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_clear  = 1'b0;
                    tmr_enable = 1'b1;
                end
            end
            SAMPLE: begin
                if (ch_q != LAST_CH) begin
                    shadow_d[ch_q] = y;
                    ch_d           = ch_q + 1'b1;
                    state_d        = SETTLE;
                end else begin
                    data_d     = {y, shadow_q};
                    valid_d    = 1'b1;
                    scan_cnt_d = scan_cnt_q + 8'd1;
                    ch_d       = '0;
                    state_d    = cont ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            scan_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign s0       = ch_q[0];
    assign s1       = ch_q[1];
    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign data     = data_q;
    assign scan_cnt = scan_cnt_q;

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream control stage for the 4:1 mux (`y` = i0..i3 selected by `{s1,s0}`). It steps the select lines through channels 0..3, holds each for a programmable settle time, and samples the mux output. It then publishes the four samples as one parallel word with a one-cycle valid strobe. It can run a single scan per start request or rescan continuously.

## Interface
- `DWELL`, default 2: settle cycles per channel before sampling. Legal range 1..15; 0 is a compile-time error.
- `CNT_W`, default 4: dwell counter width. Must hold `DWELL-1`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request; level-sampled in IDLE only.
- `cont`  in  1  continuous mode; sampled at the channel-3 sample.
- `y`  in  1  mux output, combinational from `s1`/`s0`.
- `s0`  out  1  select LSB, registered.
- `s1`  out  1  select MSB, registered.
- `busy`  out  1  high in any state other than IDLE.
- `valid`  out  1  one-cycle pulse; `data` updated this cycle.
- `data`  out  4  `data[k]` = `y` sampled while `{s1,s0}`=k.
- `scan_cnt`  out  8  completed scans, wraps 255→0.

## Operation
- States:
  - IDLE: `{s1,s0}`=00, dwell count 0.
  - SETTLE: dwell counter counts 0..DWELL-1.
  - SAMPLE: one cycle.
- IDLE → SETTLE (ch=0) when `start`=1.
- SETTLE → SAMPLE when count == DWELL-1. Otherwise the count increments.
- SAMPLE with ch<3: `shadow[ch]`←`y`, ch←ch+1, count←0, → SETTLE.
- SAMPLE with ch=3:
  - `data`←{`y`, `shadow[2:0]`}, `valid`←1, `scan_cnt`←`scan_cnt`+1.
  - If `cont`=1, → SETTLE with ch=0; otherwise → IDLE with ch=0.
- Channel encoding: `{s1,s0}` = ch, driven directly from the ch register.
- `{s1,s0}` is stable for all DWELL+1 cycles of a channel. It changes only on the edge leaving SAMPLE.
- `data` holds its last value between scans. Partial scans never reach `data`.
- `start` while `busy`=1 is ignored, with no queuing.
- `cont` falling mid-scan: the current scan completes, then IDLE.
- `cont`=1 with `start`=0 in IDLE does not start a scan.

## Timing
- Reset values: `s0`=0, `s1`=0, `busy`=0, `valid`=0, `data`=4'b0000, `scan_cnt`=0. State is IDLE, ch=0, count=0, shadow=0.
- Reset asserted mid-scan:
  - All registers clear immediately (asynchronous).
  - No `valid` is issued for the aborted scan.
  - After `rst_n` rises, the block waits in IDLE for `start`.
- `start` seen at edge N: `busy`=1 and `{s1,s0}`=00 from edge N.
- Channel k is sampled at edge N+(k+1)(DWELL+1).
- `valid`=1 and new `data` appear after edge N+4(DWELL+1). With DWELL=2 this is edge N+12.
- `valid` is high for exactly one cycle per completed scan.
- Single mode: `busy` falls on the same edge that `valid` rises.
- Continuous mode: scans repeat back to back with period 4(DWELL+1) cycles. `busy` stays 1 and `{s1,s0}` returns to 00 on the `valid` edge.
- Wrap: `scan_cnt` at 255 goes to 0 on the next `valid`.

## Structure
- Shared package `mux_scan_pkg` holds:
  - the state enum (IDLE, SETTLE, SAMPLE);
  - `NUM_CH`=4;
  - `CH_W`=2.
- One sub-module, `dwell_timer`: a clear/enable counter with `CNT_W` bits and an `expired` output at DWELL-1.
- FSM, channel register, shadow and output registers live in the top level.

## Test plan
- Bench drives `y` from a behavioural 4:1 mux with i0..i3 = 1,0,1,0.
- Reset: hold `rst_n`=0 with `start`=1 → all outputs 0; no scan starts until `rst_n`=1.
- Single scan, DWELL=2: pulse `start` → `{s1,s0}` sequences 00,01,10,11, each held 3 cycles. `valid` rises 12 cycles after start with `data`=4'b0101, `scan_cnt`=1, `busy`=0.
- Continuous: `start`, `cont`=1 → `valid` every 12 cycles, `data`=4'b0101 each time. Change i1 to 1 mid-run; the next full scan reports 4'b0111. Drop `cont` → exactly one more `valid`, then IDLE.
- Reset mid-scan: assert `rst_n`=0 while `{s1,s0}`=10 → outputs clear at once; no `valid`; `data` stays 0.
- Ignored start and wrap: pulse `start` while `busy` → scan length unchanged. Run 256 scans → `scan_cnt` returns to 0.
- DWELL=1 build: `valid` 8 cycles after `start`; each select held 2 cycles.
